zeroheti_mtimer: RTL and testbench
==================================

Name: zeroheti_mtimer

Overview:
- Memory-mapped RISC-V machine timer; bus responder at the mtimer window 0x0000_A100 to 0x0000_A114 (five 32-bit words).
- Holds a free-running 64-bit mtime with a programmable prescaler and a 64-bit mtimecmp.
- Drives the core timer interrupt.
- Receives OBI-style requests already decoded by the system interconnect; only address bits [4:2] are used internally.

Parameters:
- BaseAddr, 32'h0000_A100: window base; offset = addr_i - BaseAddr.
- PrescW, 8: prescaler field width in ctrl.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- req_i  in  1  bus request
- gnt_o  out  1  grant
- addr_i  in  32  byte address
- we_i  in  1  write enable
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error response (same cycle as rvalid_o)
- irq_o  out  1  machine timer interrupt, level

Behaviour:
- Register map (word offsets):
  - 0x00 mtime[31:0]
  - 0x04 mtime[63:32]
  - 0x08 mtimecmp[31:0]
  - 0x0C mtimecmp[63:32]
  - 0x10 ctrl: bit0 = en, bits[8+PrescW-1:8] = presc, all other bits read 0
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, ctrl = 0, prescaler count = 0.
  - gnt_o = 0 (combinational, follows req_i), rvalid_o = 0, rdata_o = 0, err_o = 0, irq_o = 0.
- Handshake:
  - gnt_o = req_i combinationally; there are no wait states.
  - The accepted request gets rvalid_o exactly one cycle later; one response per grant.
  - Back-to-back requests are allowed every cycle.
  - rdata_o is valid only with rvalid_o and is 0 for writes.
- Errors:
  - Offset >= 0x14, or addr_i[1:0] != 0, gives err_o = 1 with rvalid_o.
  - An error write has no side effect; an error read returns rdata_o = 0.
- Writes:
  - Per-byte using be_i.
  - be_i = 0 is a legal no-op with an OK response.
- Counting:
  - When en = 1, the prescaler count increments each cycle.
  - When count == presc, the count clears to 0 and mtime increments by 1. presc = 0 therefore increments mtime every cycle.
  - When en = 0, both mtime and the prescaler count hold.
  - Writing ctrl clears the prescaler count.
  - mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
- Write/increment collision: a bus write to an mtime word in the same cycle as an increment takes priority for the written bytes. The increment is dropped that cycle for the whole 64-bit value.
- Read timing: read data is sampled in the grant cycle and reflects register state before any same-cycle update.
- Interrupt:
  - irq_o is registered: irq_o <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current register values every cycle regardless of en.
  - It deasserts one cycle after mtimecmp is written above mtime.
- Reset mid-transaction: a pending response is discarded; rvalid_o = 0 after reset.

Optional Feature:
- Macro: ZEROHETI_MTIMER_SNAPSHOT_EN.
- Defined:
  - A read of 0x00 captures mtime[63:32] into a shadow register in the same cycle.
  - A subsequent read of 0x04 returns the shadow, giving coherent 64-bit reads across a low-word carry.
  - The shadow resets to 0.
  - Writes to 0x04 update both mtime[63:32] and the shadow.
- Undefined: 0x04 reads return live mtime[63:32]; no shadow register is present.

Test Plan:
- Reset, then read all five words -> 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0; irq_o = 0; each rvalid_o exactly one cycle after gnt_o.
- Write ctrl = 32'h0000_0301 (en, presc = 3), idle 40 cycles -> mtime[31:0] reads 10 (±1 for read alignment); prescaler period checked to be 4 cycles.
- Write mtime = 64'h0000_0000_FFFF_FFFE, ctrl = 1, wait 3 cycles -> mtime reads 64'h0000_0001_0000_0001. With the macro defined, read 0x00 just before carry then 0x04 -> high word 0 (shadow); without the macro -> 1.
- mtimecmp = 100, ctrl = 1 -> irq_o rises on the cycle after mtime reaches 100. Write mtimecmp_lo = 200 -> irq_o falls one cycle later.
- Access offsets 0x14 and 0x02 -> err_o = 1, rdata_o = 0, no register change. Write 0x08 with be_i = 4'b0010 and wdata_i = 32'h0000_AB00 -> mtimecmp[31:0] = 32'hFFFF_ABFF.
- Write mtime_lo = 5 in the same cycle as an increment, presc = 0 -> next read 5 + (cycles since write), not 6 + (cycles since write). Assert rst_i between grant and rvalid -> no rvalid_o is issued.

Source files
------------

// File: rtl/zeroheti_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, level irq.
// Optional coherent high-word snapshot on low-word reads: ZEROHETI_MTIMER_SNAPSHOT_EN.
module zeroheti_mtimer #(
  parameter logic [31:0] BaseAddr = 32'h0000_A100,
  parameter int unsigned PrescW   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_o
);

  localparam int unsigned NumWords = 5;
  localparam int unsigned WinBytes = NumWords * 4;

  localparam logic [2:0] WordTimeLo = 3'd0;
  localparam logic [2:0] WordTimeHi = 3'd1;
  localparam logic [2:0] WordCmpLo  = 3'd2;
  localparam logic [2:0] WordCmpHi  = 3'd3;
  localparam logic [2:0] WordCtrl   = 3'd4;

  logic [31:0]       offset;
  logic [2:0]        word;
  logic              addr_ok;
  logic              rd_en;
  logic              wr_en;
  logic              wr_any;

  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic              en_q, en_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [PrescW-1:0] cnt_q, cnt_d;
  logic              tick;
  logic [31:0]       ctrl_rd;
  logic [31:0]       rd_data;

`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
  logic [31:0]       shadow_q, shadow_d;
`endif

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = be[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

  // Address decode: the offset wraps for addresses below the base, so one compare covers both ends
  assign offset  = addr_i - BaseAddr;
  assign addr_ok = (offset < 32'(WinBytes)) && (addr_i[1:0] == 2'b00);
  assign word    = offset[4:2];
  assign gnt_o   = req_i;
  assign rd_en   = req_i & ~we_i & addr_ok;
  assign wr_en   = req_i & we_i & addr_ok;
  assign wr_any  = wr_en & (be_i != 4'b0000);

  assign tick    = en_q && (cnt_q == presc_q);
  assign ctrl_rd = 32'({presc_q, 7'b000_0000, en_q});

  // Next-state: counting first, then bus writes override the bytes they touch
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    presc_d    = presc_q;
    cnt_d      = cnt_q;

    if (en_q) begin
      cnt_d = tick ? '0 : cnt_q + PrescW'(1);
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_any) begin
      case (word)
        WordTimeLo: mtime_d = {mtime_q[63:32], merge_be(mtime_q[31:0], wdata_i, be_i)};
        WordTimeHi: mtime_d = {merge_be(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
        WordCmpLo:  mtimecmp_d[31:0]  = merge_be(mtimecmp_q[31:0], wdata_i, be_i);
        WordCmpHi:  mtimecmp_d[63:32] = merge_be(mtimecmp_q[63:32], wdata_i, be_i);
        WordCtrl: begin
          en_d = be_i[0] ? wdata_i[0] : en_q;
          for (int unsigned i = 0; i < PrescW; i++) begin
            presc_d[i] = be_i[2'((i + 8) / 8)] ? wdata_i[5'(i + 8)] : presc_q[i];
          end
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
  always_comb begin
    shadow_d = shadow_q;
    if (rd_en && (word == WordTimeLo)) begin
      shadow_d = mtime_q[63:32];
    end
    if (wr_any && (word == WordTimeHi)) begin
      shadow_d = mtime_d[63:32];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  // Read mux samples pre-update register state
  always_comb begin
    rd_data = '0;
    case (word)
      WordTimeLo: rd_data = mtime_q[31:0];
`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
      WordTimeHi: rd_data = shadow_q;
`else
      WordTimeHi: rd_data = mtime_q[63:32];
`endif
      WordCmpLo:  rd_data = mtimecmp_q[31:0];
      WordCmpHi:  rd_data = mtimecmp_q[63:32];
      WordCtrl:   rd_data = ctrl_rd;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      presc_q    <= '0;
      cnt_q      <= '0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      rvalid_o   <= req_i;
      rdata_o    <= rd_en ? rd_data : '0;
      err_o      <= req_i & ~addr_ok;
      irq_o      <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Randomized self-checking bench for zeroheti_mtimer against a transaction-level timer model.
module tb_zeroheti_mtimer;

  localparam logic [31:0] BASE = 32'h0000_A100;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  zeroheti_mtimer #(.BaseAddr(BASE), .PrescW(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: timer state plus the response expected for the cycle just granted
  logic [63:0] m_time, m_cmp, m_old_time;
  logic        m_en;
  logic [7:0]  m_presc, m_cnt;
  logic [31:0] m_shadow;
  logic        m_irq, m_rvalid, m_err, m_tick, m_ok;
  logic [31:0] m_rdata, m_off, m_ctrl;
  int          m_w;

  function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = b[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    case (w)
      0: return m_time[31:0];
`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
      1: return m_shadow;
`else
      1: return m_time[63:32];
`endif
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {16'h0000, m_presc, 7'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_time = 64'h0; m_cmp = '1; m_en = 1'b0; m_presc = 8'h0; m_cnt = 8'h0;
      m_shadow = 32'h0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
    end else begin
      m_off      = addr - BASE;
      m_ok       = (m_off < 32'd20) && (addr[1:0] == 2'b00);
      m_w        = int'(m_off[4:2]);
      m_irq      = (m_time >= m_cmp);
      m_rvalid   = req;
      m_err      = req && !m_ok;
      m_rdata    = (req && !we && m_ok) ? m_read(m_w) : 32'h0;
      m_tick     = m_en && (m_cnt == m_presc);
      m_old_time = m_time;
`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
      if (req && !we && m_ok && m_w == 0) m_shadow = m_old_time[63:32];
`endif
      if (m_en) m_cnt = m_tick ? 8'h0 : m_cnt + 8'h1;
      if (m_tick) m_time = m_time + 64'h1;
      if (req && we && m_ok && be != 4'h0) begin
        case (m_w)
          0: m_time = {m_old_time[63:32], apply_be(m_old_time[31:0], wdata, be)};
          1: begin
            m_time = {apply_be(m_old_time[63:32], wdata, be), m_old_time[31:0]};
`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
            m_shadow = m_time[63:32];
`endif
          end
          2: m_cmp[31:0]  = apply_be(m_cmp[31:0], wdata, be);
          3: m_cmp[63:32] = apply_be(m_cmp[63:32], wdata, be);
          4: begin
            m_ctrl  = apply_be({16'h0000, m_presc, 7'b0, m_en}, wdata, be);
            m_en    = m_ctrl[0];
            m_presc = m_ctrl[15:8];
            m_cnt   = 8'h0;
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison of every registered output
  always @(negedge clk) begin
    if (!rst) begin
      check("irq", irq, m_irq);
      check("rvalid", rvalid, m_rvalid);
      if (rvalid) begin
        check("rdata_model", rdata, m_rdata);
        check("err_model", err, m_err);
      end
    end
  end

  // One bus transaction, called at a falling edge; returns at the falling edge after the grant
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output logic e);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    #1 check("gnt", gnt, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    check("rvalid_after_gnt", rvalid, 1'b1);
    rd = rdata;
    e  = err;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    logic e;
    xfer(1'b1, BASE + off, b, d, r, e);
    check("wr_err", e, 1'b0);
    check("wr_rdata", r, 32'h0);
  endtask

  task automatic rd_exp(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    xfer(1'b0, BASE + off, 4'hF, 32'h0, r, e);
    check(tag, r, exp);
    check({tag, "_err"}, e, 1'b0);
  endtask

  task automatic bad_access(input string tag, input logic w, input logic [31:0] a);
    logic [31:0] r;
    logic e;
    xfer(w, a, 4'hF, 32'h1234_5678, r, e);
    check({tag, "_err"}, e, 1'b1);
    check({tag, "_rdata"}, r, 32'h0);
  endtask

  logic [31:0] rv, rdv, a_r, d_r;
  logic [31:0] vals[8];
  logic        ev, w_r;
  int          n, r_sel;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_gnt", gnt, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    rd_exp("rst_time_lo", 32'h00, 32'h0);
    rd_exp("rst_time_hi", 32'h04, 32'h0);
    rd_exp("rst_cmp_lo", 32'h08, 32'hFFFF_FFFF);
    rd_exp("rst_cmp_hi", 32'h0C, 32'hFFFF_FFFF);
    rd_exp("rst_ctrl", 32'h10, 32'h0);

    // Prescaler: presc = 3 gives one mtime increment every 4 cycles
    wr(32'h10, 32'h0000_0301, 4'hF);
    repeat (40) @(negedge clk);
    xfer(1'b0, BASE, 4'hF, 32'h0, rv, ev);
    check("presc_40_cycles", (rv >= 32'd9 && rv <= 32'd11), 1'b1);
    for (int i = 0; i < 8; i++) xfer(1'b0, BASE, 4'hF, 32'h0, vals[i], ev);
    check("presc_period_a", vals[4] - vals[0], 32'd1);
    check("presc_period_b", vals[7] - vals[3], 32'd1);
    rd_exp("ctrl_readback", 32'h10, 32'h0000_0301);

    // Low-to-high carry, exactly three increments
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    wr(32'h10, 32'h0, 4'hF);
    rd_exp("carry_lo", 32'h00, 32'h0000_0001);
    rd_exp("carry_hi", 32'h04, 32'h0000_0001);

    // Low word read just before the carry, then high word
    wr(32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    rd_exp("snap_lo0", 32'h00, 32'hFFFF_FFFE);
    rd_exp("snap_lo1", 32'h00, 32'hFFFF_FFFF);
`ifdef ZEROHETI_MTIMER_SNAPSHOT_EN
    rd_exp("snap_hi", 32'h04, 32'h0);
`else
    rd_exp("snap_hi", 32'h04, 32'h1);
`endif
    wr(32'h10, 32'h0, 4'hF);

    // Error responses and byte enables
    bad_access("rd_0x14", 1'b0, BASE + 32'h14);
    bad_access("wr_0x14", 1'b1, BASE + 32'h14);
    bad_access("rd_0x02", 1'b0, BASE + 32'h02);
    bad_access("wr_0x0a", 1'b1, BASE + 32'h0A);
    bad_access("wr_below", 1'b1, BASE - 32'h4);
    rd_exp("cmp_lo_untouched", 32'h08, 32'hFFFF_FFFF);
    wr(32'h08, 32'h0000_AB00, 4'b0010);
    rd_exp("cmp_lo_byte1", 32'h08, 32'hFFFF_ABFF);
    wr(32'h0C, 32'h0, 4'b0000);
    rd_exp("cmp_hi_be0", 32'h0C, 32'hFFFF_FFFF);

    // Interrupt rises the cycle after mtime reaches 100, falls a cycle after cmp moves above
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h0C, 32'h0, 4'hF);
    wr(32'h08, 32'd100, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    check("irq_before", irq, 1'b0);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (irq) begin
        n = i;
        break;
      end
    end
    check("irq_rise_cycle", 32'(n), 32'd101);
    wr(32'h08, 32'd200, 4'hF);
    check("irq_still_high", irq, 1'b1);
    @(negedge clk);
    check("irq_fall", irq, 1'b0);
    wr(32'h10, 32'h0, 4'hF);

    // Write to mtime wins over a same-cycle increment
    wr(32'h10, 32'h1, 4'hF);
    wr(32'h00, 32'd5, 4'hF);
    rd_exp("collide_0", 32'h00, 32'd5);
    rd_exp("collide_1", 32'h00, 32'd6);
    wr(32'h10, 32'h0, 4'hF);

    // Reset between grant and response
    req = 1'b1; we = 1'b0; addr = BASE; be = 4'hF;
    @(posedge clk);
    #1 rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid", rvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_after", rvalid, 1'b0);
    rd_exp("rst_mid_cmp", 32'h08, 32'hFFFF_FFFF);

    // Random traffic checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      r_sel = int'($urandom_range(0, 15));
      if (r_sel == 0) begin
        @(negedge clk);
      end else begin
        if (r_sel == 1) a_r = BASE + 32'($urandom_range(0, 31));
        else            a_r = BASE + 32'(4 * $urandom_range(0, 4));
        w_r = 1'($urandom_range(0, 1));
        d_r = $urandom;
        if (a_r == BASE + 32'h10) d_r = d_r & 32'hFFFF_03FF;
        if (a_r == BASE + 32'h04 || a_r == BASE + 32'h0C) d_r = d_r & 32'h0000_0003;
        xfer(w_r, a_r, 4'($urandom), d_r, rdv, ev);
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
